// File: rtl/topolar_arb_pkg.sv
// Shared types for the topolar arbiter: FSM state encoding, default data width
// and the requester-index width helper.
package topolar_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_W = 32;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/topolar_arbiter_if.sv
// Bundle of requester, CORDIC and result signals for topolar_arbiter.
// TOPOLAR_ARB_TIMEOUT_EN adds the sticky watchdog error flag err.
interface topolar_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = topolar_arb_pkg::DEF_W
);
  import topolar_arb_pkg::*;

  localparam int IDW = id_w(NREQ);

  // Every handshake here is valid/ready: a word moves on a rising clk edge where
  // both are high; valid never waits on ready and the payload holds until taken.
  logic [NREQ-1:0]   req_vld;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic              c_vld;
  logic [W-1:0]      c_x;
  logic [W-1:0]      c_y;
  logic              c_ready;
  logic              c_ovld;
  logic [W-1:0]      c_mag;
  logic [W-1:0]      c_phase;
  logic              res_vld;
  logic              res_rdy;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_mag;
  logic [W-1:0]      res_phase;
  logic              busy;
  state_t            dbg_state;
  logic [IDW-1:0]    dbg_rr_ptr;
`ifdef TOPOLAR_ARB_TIMEOUT_EN
  logic              err;
`endif

  modport master (
    input  req_vld, req_x, req_y, c_ready, c_ovld, c_mag, c_phase, res_rdy,
    output req_rdy, c_vld, c_x, c_y, res_vld, res_id, res_mag, res_phase,
           busy, dbg_state, dbg_rr_ptr
`ifdef TOPOLAR_ARB_TIMEOUT_EN
    , output err
`endif
  );

  modport slave (
    output req_vld, req_x, req_y, c_ready, c_ovld, c_mag, c_phase, res_rdy,
    input  req_rdy, c_vld, c_x, c_y, res_vld, res_id, res_mag, res_phase,
           busy, dbg_state, dbg_rr_ptr
`ifdef TOPOLAR_ARB_TIMEOUT_EN
    , input err
`endif
  );

endinterface

// File: rtl/topolar_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping past NREQ-1 back to 0.
module rr_pick
  import topolar_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  function automatic logic [IDW-1:0] slot(input logic [IDW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NREQ;
    return IDW'(s);
  endfunction

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && i_req[slot(i_ptr, k)]) begin
        o_any               = 1'b1;
        o_gnt[slot(i_ptr, k)] = 1'b1;
        o_idx               = slot(i_ptr, k);
      end
    end
  end

endmodule

// File: rtl/topolar_arbiter.sv
// Round-robin share of one rectangular-to-polar CORDIC among NREQ requesters.
// Optional BUSY watchdog and sticky err output under TOPOLAR_ARB_TIMEOUT_EN.
module topolar_arbiter
  import topolar_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               arstn,
  topolar_arbiter_if.master bus
);

  localparam int IDW = id_w(NREQ);

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id;
  logic [W-1:0]    r_x;
  logic [W-1:0]    r_y;
  logic [W-1:0]    r_mag;
  logic [W-1:0]    r_phase;
  logic            r_res_vld;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_any;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [W-1:0]    w_sel_x;
  logic [W-1:0]    w_sel_y;
  logic            w_take;
  logic            w_done;
  logic            w_tmo;
  logic            w_accept;
  logic            w_wd_hit;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req (bus.req_vld),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_x = bus.req_x[i*W +: W];
        w_sel_y = bus.req_y[i*W +: W];
      end
    end
  end

  // A new grant waits for both an idle CORDIC and an accepted previous result,
  // which is the only backpressure path since the CORDIC cannot stall.
  always_comb begin
    w_next   = r_state;
    w_take   = 1'b0;
    w_done   = 1'b0;
    w_tmo    = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      ARB: begin
        if (bus.c_ready && w_any) begin
          w_take = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: w_next = BUSY;
      BUSY: begin
        if (bus.c_ovld) begin
          w_done = 1'b1;
          w_next = RESP;
        end else if (w_wd_hit) begin
          w_tmo  = 1'b1;
          w_next = RESP;
        end
      end
      RESP: begin
        if (r_res_vld && bus.res_rdy) begin
          w_accept = 1'b1;
          w_next   = ARB;
        end
      end
      default: w_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_state   <= ARB;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_mag     <= '0;
      r_phase   <= '0;
      r_res_vld <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_x      <= w_sel_x;
        r_y      <= w_sel_y;
        r_id     <= w_gnt_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_done) begin
        r_mag     <= bus.c_mag;
        r_phase   <= bus.c_phase;
        r_res_vld <= 1'b1;
      end else if (w_tmo) begin
        r_mag     <= '0;
        r_phase   <= '0;
        r_res_vld <= 1'b1;
      end else if (w_accept) begin
        r_res_vld <= 1'b0;
      end
    end
  end

`ifdef TOPOLAR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wdog;
  logic          r_err;

  assign w_wd_hit = (r_wdog == CW'(TIMEOUT));
  assign bus.err  = r_err;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ISSUE) begin
        r_wdog <= '0;
      end else if (r_state == BUSY && !w_wd_hit) begin
        r_wdog <= r_wdog + CW'(1);
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_wd_hit = 1'b0;
`endif

  assign bus.req_rdy    = w_take ? w_gnt : '0;
  assign bus.c_vld      = (r_state == ISSUE);
  assign bus.c_x        = r_x;
  assign bus.c_y        = r_y;
  assign bus.res_vld    = r_res_vld;
  assign bus.res_id     = r_id;
  assign bus.res_mag    = r_mag;
  assign bus.res_phase  = r_phase;
  assign bus.busy       = (r_state != ARB);
  assign bus.dbg_state  = r_state;
  assign bus.dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_topolar_arbiter.sv
// Randomized bench for topolar_arbiter with a stub CORDIC (mag=x+y, phase=x-y)
// and a queue-based reference model; TOPOLAR_ARB_TIMEOUT_EN adds the watchdog case.
module tb_topolar_arbiter;
  import topolar_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;
  localparam int EW      = IDW + 2*W;

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  topolar_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  topolar_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  // Stub CORDIC: busy 17 cycles after a start, then a one-cycle result pulse.
  int           st_cnt = 0;
  logic [W-1:0] st_x, st_y;
  bit           stub_hang = 1'b0;

  assign bus.c_ready = (st_cnt == 0);

  always @(posedge clk) begin
    if (!arstn) begin
      st_cnt      <= 0;
      bus.c_ovld  <= 1'b0;
      bus.c_mag   <= '0;
      bus.c_phase <= '0;
    end else begin
      bus.c_ovld <= 1'b0;
      if (bus.c_vld) begin
        st_cnt <= 17;
        st_x   <= bus.c_x;
        st_y   <= bus.c_y;
      end else if (st_cnt > 0) begin
        st_cnt <= st_cnt - 1;
        if (st_cnt == 1 && !stub_hang) begin
          bus.c_ovld  <= 1'b1;
          bus.c_mag   <= st_x + st_y;
          bus.c_phase <= st_x - st_y;
        end
      end
    end
  end

  // Reference model state
  logic [2*W-1:0] rq[NREQ][$];
  logic [EW-1:0]  exp_q[$];
  int             gnt_log[$];
  int             mdl_ptr = 0;
  bit             inflight = 1'b0;
  logic [W-1:0]   if_x, if_y;
  int             since_hs = 100;
  int             acc_gap = 100;
  int             cvld_cnt = 0;
  int             cvld_total = 0;
  int             res_rise = 0;
  logic           prev_res_vld = 1'b0;
  logic           prev_c_ovld = 1'b0;
  logic [EW-1:0]  prev_res;
  logic [EW-1:0]  last_res = '0;
  int             rdy_mode = 0;
  int             n_chk = 0;
  int             n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick_model();
    for (int k = 0; k < NREQ; k++) begin
      if (rq[(mdl_ptr + k) % NREQ].size() != 0) return (mdl_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_vld[i] = (rq[i].size() != 0);
      if (rq[i].size() != 0) begin
        bus.req_x[i*W +: W] = rq[i][0][2*W-1:W];
        bus.req_y[i*W +: W] = rq[i][0][W-1:0];
      end else begin
        bus.req_x[i*W +: W] = '0;
        bus.req_y[i*W +: W] = '0;
      end
    end
  endtask

  task automatic push_req(input int id, input logic [W-1:0] x, input logic [W-1:0] y);
    rq[id].push_back({x, y});
    drive();
  endtask

  task automatic step();
    logic [NREQ-1:0] hs;
    logic [EW-1:0]   e;
    logic [EW-1:0]   cur;
    int              gid;
    int              gact;
    logic [W-1:0]    ex, ey;
    gid  = -1;
    gact = -1;
    @(negedge clk);
    hs = bus.req_vld & bus.req_rdy;
    since_hs++;
    acc_gap++;
    chk("busy", bus.busy, inflight);
    if (inflight) chk("rdy_idle_inflight", bus.req_rdy, 0);
    if (acc_gap == 1 && !inflight && bus.req_vld != 0 && bus.c_ready)
      chk("grant_gap", hs != 0, 1);
    if (hs != 0) begin
      gid = pick_model();
      for (int i = 0; i < NREQ; i++) if (hs[i]) gact = i;
      chk("grant_onehot", $countones(hs), 1);
      chk("grant_idx", gact, gid);
      if (gid >= 0) begin
        ex = rq[gid][0][2*W-1:W];
        ey = rq[gid][0][W-1:0];
        if (stub_hang) exp_q.push_back({IDW'(gid), W'(0), W'(0)});
        else           exp_q.push_back({IDW'(gid), ex + ey, ex - ey});
        if_x     = ex;
        if_y     = ey;
        inflight = 1'b1;
        since_hs = 0;
        cvld_cnt = 0;
        mdl_ptr  = (gid + 1) % NREQ;
        gnt_log.push_back(gid);
      end
    end
    if (bus.c_vld) begin
      cvld_cnt++;
      cvld_total++;
      chk("c_vld_lat", since_hs, 1);
      chk("c_x", bus.c_x, if_x);
      chk("c_y", bus.c_y, if_y);
    end
    cur = {bus.res_id, bus.res_mag, bus.res_phase};
    if (bus.res_vld) begin
      if (!inflight || exp_q.size() == 0) begin
        chk("spurious_res", bus.res_vld, 0);
      end else begin
        e = exp_q[0];
        chk("res_id", bus.res_id, e[2*W +: IDW]);
        chk("res_mag", bus.res_mag, e[W +: W]);
        chk("res_phase", bus.res_phase, e[0 +: W]);
        if (!prev_res_vld) begin
          res_rise++;
          chk("c_vld_once", cvld_cnt, 1);
          if (!stub_hang) chk("res_after_ovld", prev_c_ovld, 1);
        end else begin
          chk("res_stable", cur, prev_res);
        end
        if (bus.res_rdy) begin
          last_res = cur;
          void'(exp_q.pop_front());
          inflight = 1'b0;
          acc_gap  = 0;
        end
      end
    end
    prev_res_vld = bus.res_vld;
    prev_c_ovld  = bus.c_ovld;
    prev_res     = cur;
    @(posedge clk);
    #1;
    if (gid >= 0) void'(rq[gid].pop_front());
    drive();
    case (rdy_mode)
      0:       bus.res_rdy = 1'b1;
      1:       bus.res_rdy = 1'($urandom_range(0, 1));
      default: bus.res_rdy = 1'b0;
    endcase
  endtask

  task automatic drain();
    int budget;
    bit pend;
    budget = 3000;
    pend   = 1'b1;
    while (pend && budget > 0) begin
      step();
      budget--;
      pend = inflight;
      for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) pend = 1'b1;
    end
    if (pend) chk("drain_timeout", 1, 0);
  endtask

  task automatic pulse_reset();
    arstn = 1'b0;
    @(posedge clk);
    #1;
    arstn        = 1'b1;
    inflight     = 1'b0;
    exp_q.delete();
    mdl_ptr      = 0;
    since_hs     = 100;
    acc_gap      = 100;
    prev_res_vld = 1'b0;
    prev_c_ovld  = 1'b0;
    chk("rst_state", bus.dbg_state, ARB);
    chk("rst_res_vld", bus.res_vld, 0);
    chk("rst_c_vld", bus.c_vld, 0);
    chk("rst_rr_ptr", bus.dbg_rr_ptr, 0);
  endtask

  task automatic wait_state(input state_t s);
    int budget;
    budget = 200;
    while (bus.dbg_state != s && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk("wait_state_timeout", 1, 0);
  endtask

  initial begin
    int n;
    int start_rise;
    bus.req_vld = '0;
    bus.req_x   = '0;
    bus.req_y   = '0;
    bus.res_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", bus.dbg_state, ARB);
    chk("reset_req_rdy", bus.req_rdy, 0);
    chk("reset_res_vld", bus.res_vld, 0);
    chk("reset_c_vld", bus.c_vld, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rr_ptr", bus.dbg_rr_ptr, 0);
    chk("reset_res_mag", bus.res_mag, 0);
`ifdef TOPOLAR_ARB_TIMEOUT_EN
    chk("reset_err", bus.err, 0);
`endif
    arstn       = 1'b1;
    bus.res_rdy = 1'b1;

    // Single request from requester 2
    push_req(2, 32'd1024, 32'd5120);
    drain();
    chk("single_id", last_res[2*W +: IDW], 2);
    chk("single_mag", last_res[W +: W], 32'd6144);
    chk("single_phase", last_res[0 +: W], 32'hFFFF_F000);
    chk("single_c_vld_count", cvld_total, 1);

    // All requesters continuously: grants rotate 0,1,2,3,...
    pulse_reset();
    gnt_log.delete();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NREQ; i++) push_req(i, W'(i * 1024), 32'd1024);
    drain();
    chk("fair_count", gnt_log.size(), 12);
    for (int k = 0; k < gnt_log.size(); k++) chk("fair_order", gnt_log[k], k % NREQ);

    // Backpressure: hold res_rdy low for 10 cycles after res_vld
    rdy_mode = 2;
    push_req(0, 32'd77, 32'd11);
    push_req(1, 32'd300, 32'd500);
    start_rise = res_rise;
    n = 0;
    while (res_rise == start_rise && n < 200) begin
      step();
      n++;
    end
    chk("bp_res_seen", res_rise != start_rise, 1);
    n = cvld_total;
    repeat (10) step();
    chk("bp_no_new_c_vld", cvld_total, n);
    chk("bp_res_vld_held", bus.res_vld, 1);
    rdy_mode = 0;
    drain();

    // Reset while the CORDIC is busy
    push_req(3, 32'd123, 32'd456);
    wait_state(BUSY);
    repeat (3) step();
    pulse_reset();
    push_req(1, 32'd2048, 32'd1000);
    drain();
    chk("post_rst_id", last_res[2*W +: IDW], 1);
    chk("post_rst_mag", last_res[W +: W], 32'd3048);

    // Wrap-around from rr_ptr=3 with only requesters 0 and 3
    push_req(2, 32'd5, 32'd6);
    drain();
    chk("wrap_ptr", bus.dbg_rr_ptr, 3);
    gnt_log.delete();
    push_req(3, 32'd10, 32'd20);
    push_req(3, 32'd30, 32'd40);
    push_req(0, 32'd50, 32'd60);
    drain();
    chk("wrap_count", gnt_log.size(), 3);
    if (gnt_log.size() == 3) begin
      chk("wrap_g0", gnt_log[0], 3);
      chk("wrap_g1", gnt_log[1], 0);
      chk("wrap_g2", gnt_log[2], 3);
    end

    // Randomized traffic with random result acceptance
    rdy_mode = 1;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(0, NREQ - 1);
        if (rq[n].size() < 3) push_req(n, W'($urandom), W'($urandom));
      end
      step();
    end
    rdy_mode = 0;
    drain();

`ifdef TOPOLAR_ARB_TIMEOUT_EN
    // Watchdog: stub never returns a result
    chk("pre_tmo_err", bus.err, 0);
    stub_hang = 1'b1;
    push_req(2, 32'd9, 32'd9);
    n = cvld_total;
    start_rise = 0;
    while (cvld_total == n && start_rise < 200) begin
      step();
      start_rise++;
    end
    start_rise = res_rise;
    n = 0;
    while (res_rise == start_rise && n < 300) begin
      step();
      n++;
    end
    chk("tmo_window", (n >= TIMEOUT && n <= TIMEOUT + 3), 1);
    drain();
    chk("tmo_err", bus.err, 1);
    stub_hang = 1'b0;
    push_req(0, 32'd1, 32'd2);
    drain();
    chk("tmo_err_sticky", bus.err, 1);
    chk("tmo_recover_mag", last_res[W +: W], 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/topolar_arbiter.md
Name: topolar_arbiter

Overview:
- Round-robin arbiter that shares one iterative rectangular-to-polar CORDIC (topolar_fsm, 16 stages) between NREQ independent requesters, e.g. FFT bin streams from several channels.
- Accepts (x, y) from one requester at a time and issues it to the CORDIC.
- Waits for the CORDIC result, then returns magnitude/phase tagged with the requester index through a valid/ready result port.
- Sits between the FFT output buffers and the postprocess stage.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 32, signed data width of x, y, mag, phase.
- TIMEOUT, 64, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- arstn  in  1  synchronous active-low reset. It is also used inverted as the CORDIC's rst.
- req_vld  in  NREQ  per-requester valid.
- req_rdy  out  NREQ  per-requester ready.
- req_x  in  NREQ*W  packed signed x; requester i occupies bits [i*W +: W].
- req_y  in  NREQ*W  packed signed y, same packing.
- c_vld  out  1  CORDIC start (drives i_vld).
- c_x, c_y  out  W  operands to CORDIC.
- c_ready  in  1  CORDIC idle.
- c_ovld  in  1  CORDIC result valid (o_vld).
- c_mag, c_phase  in  W  CORDIC results.
- res_vld  out  1  result valid.
- res_rdy  in  1  result accept.
- res_id  out  $clog2(NREQ)  requester index of result.
- res_mag, res_phase  out  W  result.
- busy  out  1  high in any state except ARB.

Behaviour:
- Reset (arstn=0 at posedge): state=ARB, rr_ptr=0, all outputs 0, req_rdy=0. Reset mid-operation abandons the transaction; the CORDIC is reset by the same edge, so no stale c_ovld follows.
- States: ARB, ISSUE, BUSY, RESP.
- ARB:
  - If c_ready=1, grant the first requester with req_vld=1, searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - req_rdy is one-hot on the granted index, combinational from req_vld/rr_ptr/c_ready/state. It is 0 in every other state.
  - On handshake: latch x, y and id; rr_ptr <= id+1 (mod NREQ); go to ISSUE.
  - No req_vld, or c_ready=0: stay in ARB.
- ISSUE: c_vld=1 for exactly one cycle with c_x/c_y = latched values; go to BUSY. c_x/c_y stay stable until the next ISSUE.
- BUSY: wait for c_ovld=1. On that cycle capture c_mag/c_phase into res_mag/res_phase and set res_vld=1; go to RESP.
- RESP: hold res_* stable while res_vld=1 and res_rdy=0. When res_vld&&res_rdy, clear res_vld and go to ARB.
- No new grant is issued until the result has been accepted. This gives backpressure, since the CORDIC itself has none.
- Latency: request handshake at cycle t; c_vld at t+1; res_vld at the cycle after c_ovld. Minimum repeat interval per transaction = 2 + CORDIC latency + 1 + result wait.
- c_ovld outside BUSY is ignored.
- Simultaneous requests: exactly one is granted; the others keep req_vld and must not drop data.
- Fairness: with all NREQ requesting continuously, grants go 0,1,...,NREQ-1,0,...
- Arithmetic: pass-through only; no width change or rounding.

Optional Feature:
- Macro TOPOLAR_ARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit counter runs in BUSY.
  - If it reaches TIMEOUT without c_ovld: go to RESP with res_mag=0, res_phase=0, and a sticky output err (1 bit, added port) set. err clears only on reset.
  - The counter clears on entry to BUSY.
- Undefined: no counter, no err port; BUSY waits indefinitely.

Decomposition:
- Package topolar_arb_pkg: state enum (ARB, ISSUE, BUSY, RESP), default W, and the id-width function.
- One sub-module rr_pick: combinational round-robin priority picker taking req mask and rr_ptr, producing a one-hot grant and its index, with an any-grant flag.
- The top level holds the FSM, operand/result registers and the optional watchdog.

Test Plan:
- Use a stub CORDIC model: c_ready low for 17 cycles after c_vld, returns mag=x+y, phase=x-y with a one-cycle c_ovld.
- Single request: req 2 sends x=1024, y=5120, res_rdy=1 → res_id=2, res_mag=6144, res_phase=-4096; c_vld pulses once; res_vld 1 cycle after c_ovld.
- All 4 requesting continuously with x=i*1024, y=1024 → res_id sequence 0,1,2,3,0,...; each result correct; no request lost.
- Backpressure: hold res_rdy=0 for 10 cycles after res_vld → res_* stable, req_rdy all 0, no new c_vld; release → next grant within 1 cycle in ARB.
- Reset mid-BUSY: drop arstn for 1 cycle → next cycle state ARB, res_vld=0, c_vld=0, rr_ptr=0; a fresh request from req 1 completes normally.
- Wrap-around: rr_ptr=3 with only requesters 0 and 3 active → grant 3, then 0, then 3.
- With TOPOLAR_ARB_TIMEOUT_EN: stub never asserts c_ovld → res_vld after TIMEOUT=64 cycles, res_mag=0, err=1 sticky.
